// File: rtl/pipelined_logic_reduce.sv
// pipelined_logic_reduce: N_IN-operand bitwise AND/OR/XOR/NAND reduction tree spread
// over STAGES register levels with a valid/ready handshake and full backpressure.
module pipelined_logic_reduce #(
  parameter int WIDTH  = 8,
  parameter int N_IN   = 4,
  parameter int STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [1:0]            in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy
);
  localparam int L  = $clog2(N_IN);
  localparam int P  = (L + STAGES - 1) / STAGES;
  localparam int DW = N_IN * WIDTH;
  typedef logic [DW-1:0] vec_t;

  function automatic int nodes(input int l);
    int n;
    n = N_IN;
    for (int k = 0; k < L; k++)
      if (k < l) n = (n + 1) / 2;
    return n;
  endfunction

  // One tree level: pairs combine, an odd last node passes through, dead nodes are zeroed.
  function automatic vec_t pair_level(input vec_t x, input int n, input logic [1:0] op);
    logic [WIDTH-1:0] a, b;
    vec_t r;
    r = '0;
    for (int i = 0; i < N_IN / 2; i++) begin
      a = x[2*i*WIDTH +: WIDTH];
      b = x[(2*i+1)*WIDTH +: WIDTH];
      if (2 * i + 1 < n) r[i*WIDTH +: WIDTH] = op == 2'b01 ? a | b : op == 2'b10 ? a ^ b : a & b;
    end
    if (n % 2 == 1) r[(n/2)*WIDTH +: WIDTH] = x[(n-1)*WIDTH +: WIDTH];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] fold(input vec_t x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < N_IN; i++) r = r | x[i*WIDTH +: WIDTH];
    return r;
  endfunction

  logic [STAGES-1:0] v, nxt_v;
  logic [STAGES:0]   rdy;
  vec_t              d [STAGES];
  vec_t              nxt_d [STAGES];
  logic [1:0]        o [STAGES];
  logic [1:0]        nxt_o [STAGES];
  logic [WIDTH-1:0]  f;

  always_comb begin
    logic       uv;
    logic [1:0] uo;
    vec_t       ud, x;
    rdy[STAGES] = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) rdy[s] = !v[s] || rdy[s+1];
    uv = in_valid;
    ud = in_data;
    uo = in_op;
    for (int s = 0; s < STAGES; s++) begin
      x = ud;
      for (int l = 0; l < L; l++)
        if (l >= s * P && l < (s + 1) * P) x = pair_level(x, nodes(l), uo);
      nxt_v[s] = uv;
      nxt_d[s] = x;
      nxt_o[s] = uo;
      uv = v[s];
      ud = d[s];
      uo = o[s];
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      for (int s = 0; s < STAGES; s++) begin
        d[s] <= '0;
        o[s] <= 2'b00;
      end
    end else
      for (int s = 0; s < STAGES; s++)
        if (rdy[s]) begin
          v[s] <= nxt_v[s];
          if (nxt_v[s]) begin
            d[s] <= nxt_d[s];
            o[s] <= nxt_o[s];
          end
        end

  // Only node 0 survives the full tree, so the OR-fold just selects it; NAND inverts last.
  assign f         = fold(d[STAGES-1]);
  assign out_data  = o[STAGES-1] == 2'b11 ? ~f : f;
  assign out_valid = v[STAGES-1];
  assign in_ready  = rdy[0];
  assign busy      = |v;
endmodule

// File: tb/tb_pipelined_logic_reduce.sv
// tb_pipelined_logic_reduce: directed checks on fixed configurations plus a scoreboarded
// random sweep over N_IN x STAGES against a sequential-fold reference reduction.
module tb_pipelined_logic_reduce;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] OPS = 32'hFF3CF0FF;
  logic [7:0] expv [4] = '{8'h30, 8'hFF, 8'hCC, 8'hCF};

  logic a_rn, a_iv, a_ir, a_ov, a_or, a_bz;
  logic [31:0] a_id;
  logic [1:0] a_op;
  logic [7:0] a_od;
  logic b_rn, b_iv, b_ir, b_ov, b_or, b_bz;
  logic [31:0] b_id;
  logic [1:0] b_op;
  logic [7:0] b_od;

  pipelined_logic_reduce #(.WIDTH(8), .N_IN(4), .STAGES(2)) dut_a (
    .clk(clk), .rst_n(a_rn), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id), .in_op(a_op),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .busy(a_bz));
  pipelined_logic_reduce #(.WIDTH(8), .N_IN(4), .STAGES(3)) dut_b (
    .clk(clk), .rst_n(b_rn), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id), .in_op(b_op),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .busy(b_bz));

  for (genvar g = 0; g < 16; g++) begin : g_sw
    localparam int N = g < 4 ? 2 : g < 8 ? 3 : g < 12 ? 5 : 8;
    localparam int S = g % 4 + 1;
    logic rn, iv, ir, ov, orr, bz, hold;
    logic [N*8-1:0] id;
    logic [1:0] iop;
    logic [7:0] od, hd;
    logic [7:0] q [$];

    pipelined_logic_reduce #(.WIDTH(8), .N_IN(N), .STAGES(S)) dut (
      .clk(clk), .rst_n(rn), .in_valid(iv), .in_ready(ir), .in_data(id), .in_op(iop),
      .out_valid(ov), .out_ready(orr), .out_data(od), .busy(bz));

    function automatic logic [7:0] model(input logic [N*8-1:0] x, input logic [1:0] op);
      logic [7:0] r;
      r = x[7:0];
      for (int k = 1; k < N; k++)
        r = op == 2'b01 ? r | x[k*8 +: 8] : op == 2'b10 ? r ^ x[k*8 +: 8] : r & x[k*8 +: 8];
      return op == 2'b11 ? ~r : r;
    endfunction

    task automatic shuffle;
      for (int k = 0; k < N; k++) id[k*8 +: 8] = 8'($urandom);
      iop = 2'($urandom);
    endtask

    initial begin : stim
      int lat;
      rn = 0; iv = 0; orr = 1; id = '0; iop = 2'b00;
      repeat (3) @(posedge clk);
      #1 rn = 1;
      tick();
      shuffle();
      iv = 1;
      tick();
      iv = 0;
      lat = 1;
      while (!ov && lat < 10) begin
        tick();
        lat++;
      end
      chk($sformatf("sw%0d_latency", g), lat, S);
      repeat (400) begin
        tick();
        shuffle();
        iv = 1'($urandom_range(0, 1));
        orr = $urandom_range(0, 3) != 0;
      end
      tick();
      iv = 0;
      orr = 1;
      repeat (S + 2) tick();
      chk($sformatf("sw%0d_drained", g), q.size(), 0);
      chk($sformatf("sw%0d_idle_busy", g), bz, 0);
      done_cnt++;
    end

    // Handshakes are decided at the negedge, ahead of the edge that performs them.
    always @(negedge clk) begin
      if (!rn) begin
        q.delete();
        hold = 0;
      end else begin
        chk($sformatf("sw%0d_in_ready", g), ir, q.size() < S || orr);
        chk($sformatf("sw%0d_busy", g), bz, q.size() != 0);
        if (hold) chk($sformatf("sw%0d_stable", g), od, hd);
        if (q.size() == 0) chk($sformatf("sw%0d_no_spurious", g), ov, 0);
        else if (ov && orr) chk($sformatf("sw%0d_data", g), od, q.pop_front());
        if (iv && ir) q.push_back(model(id, iop));
        hold = ov && !orr;
        hd = od;
      end
    end
  end

  initial begin
    a_rn = 0; b_rn = 0; a_iv = 0; b_iv = 0; a_or = 1; b_or = 0;
    a_id = OPS; b_id = OPS; a_op = 2'b00; b_op = 2'b00;
    #2;
    chk("rst_in_ready", a_ir, 1);
    chk("rst_out_valid", a_ov, 0);
    chk("rst_busy", a_bz, 0);
    chk("rst_out_data", a_od, 0);
    repeat (2) tick();
    a_rn = 1; b_rn = 1;
    tick();
    chk("release_in_ready", a_ir, 1);
    for (int k = 0; k < 4; k++) begin
      a_op = 2'(k);
      a_iv = 1;
      chk("basic_in_ready", a_ir, 1);
      tick();
      a_iv = 0;
      chk("basic_early_valid", a_ov, 0);
      tick();
      chk("basic_valid", a_ov, 1);
      chk($sformatf("basic_op%0d", k), a_od, expv[k]);
    end
    for (int c = 0; c < 5; c++) begin
      if (c < 4) begin
        a_op = 2'(3 - c);
        a_iv = 1;
        chk("b2b_in_ready", a_ir, 1);
      end else a_iv = 0;
      tick();
      if (c == 0) chk("b2b_first_empty", a_ov, 0);
      else begin
        chk("b2b_valid", a_ov, 1);
        chk($sformatf("b2b_data%0d", c - 1), a_od, expv[4-c]);
      end
    end
    tick();
    chk("b2b_drained", a_ov, 0);
    a_or = 0; a_op = 2'b00; a_iv = 1;
    chk("bp_ready0", a_ir, 1);
    tick();
    chk("bp_valid_after1", a_ov, 0);
    a_op = 2'b01;
    chk("bp_ready1", a_ir, 1);
    tick();
    a_op = 2'b10;
    chk("bp_full_ready", a_ir, 0);
    chk("bp_valid", a_ov, 1);
    chk("bp_data", a_od, 8'h30);
    tick();
    chk("bp_still_full", a_ir, 0);
    chk("bp_stable", a_od, 8'h30);
    a_or = 1;
    #1;
    chk("bp_ready_passthru", a_ir, 1);
    tick();
    a_or = 0; a_iv = 0;
    #1;
    chk("bp_second", a_od, 8'hFF);
    chk("bp_occupancy_kept", a_ir, 0);
    a_or = 1;
    tick();
    chk("bp_third_valid", a_ov, 1);
    chk("bp_third", a_od, 8'hCC);
    tick();
    chk("bp_empty_valid", a_ov, 0);
    chk("bp_empty_busy", a_bz, 0);
    b_op = 2'b00; b_iv = 1;
    tick();
    b_iv = 0;
    repeat (2) tick();
    chk("bub_first_valid", b_ov, 1);
    b_op = 2'b01; b_iv = 1;
    tick();
    b_op = 2'b10;
    tick();
    b_iv = 0;
    chk("bub_busy", b_bz, 1);
    chk("bub_full", b_ir, 0);
    chk("bub_head", b_od, 8'h30);
    b_or = 1;
    #1;
    chk("bub_ready", b_ir, 1);
    tick();
    chk("bub_second", b_od, 8'hFF);
    tick();
    chk("bub_third", b_od, 8'hCC);
    tick();
    chk("bub_empty", b_ov, 0);
    chk("bub_idle", b_bz, 0);
    a_op = 2'b00; a_iv = 1;
    tick();
    a_op = 2'b01;
    tick();
    a_iv = 0;
    chk("rmid_inflight", a_ov, 1);
    #2 a_rn = 0;
    #1;
    chk("rmid_valid", a_ov, 0);
    chk("rmid_busy", a_bz, 0);
    chk("rmid_ready", a_ir, 1);
    chk("rmid_data", a_od, 0);
    @(posedge clk);
    #3 a_rn = 1;
    repeat (3) begin
      tick();
      chk("rmid_no_stale", a_ov, 0);
      chk("rmid_idle", a_bz, 0);
    end
    for (int c = 0; c < 20000 && done_cnt < 16; c++) @(posedge clk);
    chk("sweep_done", done_cnt, 16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
